// File: rtl/controle_multiciclo_param_if.sv
// Control-bus bundle between the multicycle controller and its datapath:
// instruction fields and ALU flags in, mux selects and write enables out.
interface controle_multiciclo_param_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       OPCODE;
  logic [5:0]       FUNCT;
  logic [5:0]       flags;
  logic [6:0]       can_write;
  logic [1:0]       PC_source;
  logic [2:0]       Adress_source;
  logic             M_ULAA;
  logic [1:0]       M_ULAB;
  logic [2:0]       ula_op;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             cause;
  logic             reset_out;
  logic [CNT_W-1:0] instr_count;

  // Datapath / instruction-register side.
  modport master (
    output OPCODE, FUNCT, flags,
    input  can_write, PC_source, Adress_source, M_ULAA, M_ULAB, ula_op,
    input  reg_dst, mem_to_reg, cause, reset_out, instr_count
  );

  // Controller side.
  modport slave (
    input  OPCODE, FUNCT, flags,
    output can_write, PC_source, Adress_source, M_ULAA, M_ULAB, ula_op,
    output reg_dst, mem_to_reg, cause, reset_out, instr_count
  );
endinterface

// File: rtl/controle_multiciclo_param.sv
// Multicycle MIPS-subset control FSM with configurable memory wait states,
// overflow/illegal-instruction exception path and retired-instruction counter.
module controle_multiciclo_param #(
  parameter int MEM_WAIT = 2,
  parameter int CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  controle_multiciclo_param_if.slave bus
);

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_R, S_WB_I,
    S_MEM_ADDR, S_MEM_READ, S_WB_MEM, S_MEM_WRITE, S_BRANCH, S_JUMP, S_EXC
  } state_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             cause_q, cause_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] count_q;
  logic             retire;
  logic [2:0]       r_op;
  logic             unused_flags;

  // R-type funct -> ALU op; zero marks an unsupported funct.
  function automatic logic [2:0] r_ula_op(input logic [5:0] f);
    case (f)
      FN_ADD:  return 3'd1;
      FN_SUB:  return 3'd2;
      FN_AND:  return 3'd3;
      FN_OR:   return 3'd4;
      FN_SLT:  return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  assign r_op         = r_ula_op(bus.FUNCT);
  assign unused_flags = ^{bus.flags[5:3], bus.flags[1]};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RST;
      cnt_q   <= '0;
      cause_q <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      ovf_q   <= ovf_d;
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

  assign bus.cause       = cause_q;
  assign bus.instr_count = count_q;

  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no
    // path through the case statement can infer a latch.
    state_d           = state_q;
    cnt_d             = '0;
    cause_d           = cause_q;
    ovf_d             = ovf_q;
    retire            = 1'b0;
    bus.can_write     = '0;
    bus.PC_source     = 2'd0;
    bus.Adress_source = 3'd0;
    bus.M_ULAA        = 1'b0;
    bus.M_ULAB        = 2'd0;
    bus.ula_op        = 3'd0;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reset_out     = 1'b0;

    case (state_q)
      S_RST: begin
        bus.reset_out = 1'b1;
        state_d       = S_FETCH;
      end
      S_FETCH: begin
        bus.M_ULAB = 2'd1;
        bus.ula_op = 3'd1;
        if (cnt_q == WAIT_LAST) begin
          bus.can_write[2] = 1'b1;
          bus.can_write[0] = 1'b1;
          state_d          = S_DECODE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DECODE: begin
        // Speculative branch target (PC + imm<<2) lands in aluout.
        bus.can_write[4] = 1'b1;
        bus.can_write[5] = 1'b1;
        bus.M_ULAB       = 2'd3;
        bus.ula_op       = 3'd1;
        case (bus.OPCODE)
          OP_R: begin
            if (r_op != 3'd0) state_d = S_EXEC_R;
            else begin
              state_d = S_EXC;
              cause_d = 1'b1;
            end
          end
          OP_ADDI:       state_d = S_EXEC_I;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          OP_HALT:       state_d = S_RST;
          default: begin
            state_d = S_EXC;
            cause_d = 1'b1;
          end
        endcase
      end
      S_EXEC_R: begin
        bus.M_ULAA       = 1'b1;
        bus.ula_op       = r_op;
        bus.can_write[5] = 1'b1;
        ovf_d   = ((bus.FUNCT == FN_ADD) || (bus.FUNCT == FN_SUB)) && bus.flags[0];
        state_d = S_WB_R;
      end
      S_EXEC_I: begin
        bus.M_ULAA       = 1'b1;
        bus.M_ULAB       = 2'd2;
        bus.ula_op       = 3'd1;
        bus.can_write[5] = 1'b1;
        ovf_d            = bus.flags[0];
        state_d          = S_WB_I;
      end
      S_WB_R, S_WB_I: begin
        if (ovf_q) begin
          state_d = S_EXC;
          cause_d = 1'b0;
        end else begin
          bus.can_write[3] = 1'b1;
          bus.reg_dst      = (state_q == S_WB_R);
          retire           = 1'b1;
          state_d          = S_FETCH;
        end
      end
      S_MEM_ADDR: begin
        bus.M_ULAA       = 1'b1;
        bus.M_ULAB       = 2'd2;
        bus.ula_op       = 3'd1;
        bus.can_write[5] = 1'b1;
        state_d          = (bus.OPCODE == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        bus.Adress_source = 3'd1;
        if (cnt_q == WAIT_LAST) state_d = S_WB_MEM;
        else cnt_d = cnt_q + 4'd1;
      end
      S_WB_MEM: begin
        bus.can_write[3]  = 1'b1;
        bus.mem_to_reg    = 1'b1;
        bus.Adress_source = 3'd1;
        retire            = 1'b1;
        state_d           = S_FETCH;
      end
      S_MEM_WRITE: begin
        bus.Adress_source = 3'd1;
        bus.can_write[1]  = 1'b1;
        retire            = 1'b1;
        state_d           = S_FETCH;
      end
      S_BRANCH: begin
        // The ALU compares A and B this cycle, so the PC write follows zero live.
        bus.M_ULAA       = 1'b1;
        bus.ula_op       = 3'd2;
        bus.PC_source    = 2'd1;
        bus.can_write[0] = (bus.OPCODE == OP_BNE) ? !bus.flags[2] : bus.flags[2];
        retire           = 1'b1;
        state_d          = S_FETCH;
      end
      S_JUMP: begin
        bus.can_write[0] = 1'b1;
        bus.PC_source    = 2'd2;
        retire           = 1'b1;
        state_d          = S_FETCH;
      end
      S_EXC: begin
        // PC was already advanced in FETCH; EPC gets PC-4, PC gets the vector.
        bus.can_write[6] = 1'b1;
        bus.can_write[0] = 1'b1;
        bus.M_ULAB       = 2'd1;
        bus.ula_op       = 3'd2;
        bus.PC_source    = 2'd3;
        state_d          = S_FETCH;
      end
      default: state_d = S_RST;
    endcase
  end

endmodule

// File: tb/tb_controle_multiciclo_param.sv
// Directed bench: DUT A (MEM_WAIT=2, 32-bit counter) runs every instruction class,
// DUT B (MEM_WAIT=0, 4-bit counter) covers zero-wait loads, counter wrap and async abort.
module tb_controle_multiciclo_param;

  localparam int W_A = 2;

  // Packed view: {can_write, PC_source, Adress_source, M_ULAA, M_ULAB, ula_op,
  //               reg_dst, mem_to_reg, reset_out}
  localparam logic [20:0] E_RST     = {7'b0000000, 2'd0, 3'd0, 1'b0, 2'd0, 3'd0, 3'b001};
  localparam logic [20:0] E_FETCH   = {7'b0000000, 2'd0, 3'd0, 1'b0, 2'd1, 3'd1, 3'b000};
  localparam logic [20:0] E_FETCH_L = {7'b0000101, 2'd0, 3'd0, 1'b0, 2'd1, 3'd1, 3'b000};
  localparam logic [20:0] E_DECODE  = {7'b0110000, 2'd0, 3'd0, 1'b0, 2'd3, 3'd1, 3'b000};
  localparam logic [20:0] E_EXEC_I  = {7'b0100000, 2'd0, 3'd0, 1'b1, 2'd2, 3'd1, 3'b000};
  localparam logic [20:0] E_MADDR   = {7'b0100000, 2'd0, 3'd0, 1'b1, 2'd2, 3'd1, 3'b000};
  localparam logic [20:0] E_WB_R    = {7'b0001000, 2'd0, 3'd0, 1'b0, 2'd0, 3'd0, 3'b100};
  localparam logic [20:0] E_WB_I    = {7'b0001000, 2'd0, 3'd0, 1'b0, 2'd0, 3'd0, 3'b000};
  localparam logic [20:0] E_IDLE    = 21'd0;
  localparam logic [20:0] E_EXC     = {7'b1000001, 2'd3, 3'd0, 1'b0, 2'd1, 3'd2, 3'b000};
  localparam logic [20:0] E_MEM_RD  = {7'b0000000, 2'd0, 3'd1, 1'b0, 2'd0, 3'd0, 3'b000};
  localparam logic [20:0] E_WB_MEM  = {7'b0001000, 2'd0, 3'd1, 1'b0, 2'd0, 3'd0, 3'b010};
  localparam logic [20:0] E_MEM_WR  = {7'b0000010, 2'd0, 3'd1, 1'b0, 2'd0, 3'd0, 3'b000};
  localparam logic [20:0] E_BR_T    = {7'b0000001, 2'd1, 3'd0, 1'b1, 2'd0, 3'd2, 3'b000};
  localparam logic [20:0] E_BR_N    = {7'b0000000, 2'd1, 3'd0, 1'b1, 2'd0, 3'd2, 3'b000};
  localparam logic [20:0] E_JUMP    = {7'b0000001, 2'd2, 3'd0, 1'b0, 2'd0, 3'd0, 3'b000};

  logic clk;
  logic rst_a, rst_b;
  int   checks   = 0;
  int   failures = 0;

  controle_multiciclo_param_if #(.CNT_W(32)) bus_a ();
  controle_multiciclo_param_if #(.CNT_W(4))  bus_b ();

  controle_multiciclo_param #(.MEM_WAIT(W_A), .CNT_W(32)) dut_a (
    .clk(clk), .reset(rst_a), .bus(bus_a.slave)
  );
  controle_multiciclo_param #(.MEM_WAIT(0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(rst_b), .bus(bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [20:0] obs_a();
    return {bus_a.can_write, bus_a.PC_source, bus_a.Adress_source, bus_a.M_ULAA,
            bus_a.M_ULAB, bus_a.ula_op, bus_a.reg_dst, bus_a.mem_to_reg, bus_a.reset_out};
  endfunction

  function automatic logic [20:0] obs_b();
    return {bus_b.can_write, bus_b.PC_source, bus_b.Adress_source, bus_b.M_ULAA,
            bus_b.M_ULAB, bus_b.ula_op, bus_b.reg_dst, bus_b.mem_to_reg, bus_b.reset_out};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic [5:0] op, input logic [5:0] fn, input logic [5:0] fl);
    bus_a.OPCODE = op;
    bus_a.FUNCT  = fn;
    bus_a.flags  = fl;
  endtask

  task automatic test_reset();
    rst_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs_a() !== E_RST) begin
        failures++;
        $display("FAIL reset_hold cyc%0d: got %h expected %h", i, obs_a(), E_RST);
      end
    end
    checks++;
    if (bus_a.instr_count !== 32'd0 || bus_a.cause !== 1'b0) begin
      failures++;
      $display("FAIL reset_regs: count %0d cause %b, expected 0 0", bus_a.instr_count, bus_a.cause);
    end
    rst_a = 1'b1;
    checks++;
    if (obs_a() !== E_RST) begin
      failures++;
      $display("FAIL reset_release: got %h expected %h", obs_a(), E_RST);
    end
    tick();
    checks++;
    if (obs_a() !== E_FETCH) begin
      failures++;
      $display("FAIL first_fetch: got %h expected %h", obs_a(), E_FETCH);
    end
  endtask

  task automatic test_r_add();
    logic [20:0] seq [$];
    set_a(6'h00, 6'h20, 6'h00);
    seq = '{E_FETCH, E_FETCH, E_FETCH_L, E_DECODE,
            {7'b0100000, 2'd0, 3'd0, 1'b1, 2'd0, 3'd1, 3'b000}, E_WB_R};
    for (int i = 0; i < seq.size(); i++) begin
      checks++;
      if (obs_a() !== seq[i]) begin
        failures++;
        $display("FAIL r_add cyc%0d: got %h expected %h", i, obs_a(), seq[i]);
      end
      tick();
    end
    checks++;
    if (bus_a.instr_count !== 32'd1) begin
      failures++;
      $display("FAIL r_add_retire: got %0d expected 1", bus_a.instr_count);
    end
  endtask

  task automatic test_r_funct();
    logic [5:0]  fn_tab [4] = '{6'h22, 6'h24, 6'h25, 6'h2A};
    logic [2:0]  op_tab [4] = '{3'd2, 3'd3, 3'd4, 3'd7};
    logic [5:0]  fl_tab [4] = '{6'h00, 6'h01, 6'h01, 6'h01};
    logic [20:0] seq [$];
    for (int k = 0; k < 4; k++) begin
      set_a(6'h00, fn_tab[k], fl_tab[k]);
      seq = '{E_FETCH, E_FETCH, E_FETCH_L, E_DECODE,
              {7'b0100000, 2'd0, 3'd0, 1'b1, 2'd0, op_tab[k], 3'b000}, E_WB_R};
      for (int i = 0; i < seq.size(); i++) begin
        checks++;
        if (obs_a() !== seq[i]) begin
          failures++;
          $display("FAIL r_funct%0d cyc%0d: got %h expected %h", k, i, obs_a(), seq[i]);
        end
        tick();
      end
    end
    checks++;
    if (bus_a.instr_count !== 32'd5) begin
      failures++;
      $display("FAIL r_funct_retire: got %0d expected 5", bus_a.instr_count);
    end
  endtask

  task automatic test_illegal();
    logic [5:0]  op_tab [2] = '{6'h11, 6'h00};
    logic [20:0] seq [$];
    seq = '{E_FETCH, E_FETCH, E_FETCH_L, E_DECODE, E_EXC};
    for (int k = 0; k < 2; k++) begin
      set_a(op_tab[k], 6'h21, 6'h00);
      for (int i = 0; i < seq.size(); i++) begin
        checks++;
        if (obs_a() !== seq[i]) begin
          failures++;
          $display("FAIL illegal%0d cyc%0d: got %h expected %h", k, i, obs_a(), seq[i]);
        end
        if (i == 4) begin
          checks++;
          if (bus_a.cause !== 1'b1) begin
            failures++;
            $display("FAIL illegal%0d_cause: got %b expected 1", k, bus_a.cause);
          end
        end
        tick();
      end
    end
    checks++;
    if (bus_a.instr_count !== 32'd5 || bus_a.cause !== 1'b1) begin
      failures++;
      $display("FAIL illegal_after: count %0d cause %b, expected 5 1", bus_a.instr_count, bus_a.cause);
    end
  endtask

  task automatic test_addi();
    logic [20:0] seq [$];
    set_a(6'h08, 6'h00, 6'h00);
    seq = '{E_FETCH, E_FETCH, E_FETCH_L, E_DECODE, E_EXEC_I, E_WB_I};
    for (int i = 0; i < seq.size(); i++) begin
      checks++;
      if (obs_a() !== seq[i]) begin
        failures++;
        $display("FAIL addi cyc%0d: got %h expected %h", i, obs_a(), seq[i]);
      end
      tick();
    end
    checks++;
    if (bus_a.instr_count !== 32'd6) begin
      failures++;
      $display("FAIL addi_retire: got %0d expected 6", bus_a.instr_count);
    end
    // Overflow reported only while EXEC_I is active.
    seq = '{E_FETCH, E_FETCH, E_FETCH_L, E_DECODE, E_EXEC_I, E_IDLE, E_EXC};
    for (int i = 0; i < seq.size(); i++) begin
      bus_a.flags = (i == 4) ? 6'h01 : 6'h00;
      checks++;
      if (obs_a() !== seq[i]) begin
        failures++;
        $display("FAIL addi_ovf cyc%0d: got %h expected %h", i, obs_a(), seq[i]);
      end
      if (i == 6) begin
        checks++;
        if (bus_a.cause !== 1'b0) begin
          failures++;
          $display("FAIL addi_ovf_cause: got %b expected 0", bus_a.cause);
        end
      end
      tick();
    end
    checks++;
    if (bus_a.instr_count !== 32'd6) begin
      failures++;
      $display("FAIL addi_ovf_noretire: got %0d expected 6", bus_a.instr_count);
    end
  endtask

  task automatic test_branch();
    logic [5:0]  op_tab [3] = '{6'h04, 6'h05, 6'h05};
    logic [5:0]  fl_tab [3] = '{6'h04, 6'h04, 6'h00};
    logic [20:0] ex_tab [3] = '{E_BR_T, E_BR_N, E_BR_T};
    logic [20:0] seq [$];
    for (int k = 0; k < 3; k++) begin
      set_a(op_tab[k], 6'h00, fl_tab[k]);
      seq = '{E_FETCH, E_FETCH, E_FETCH_L, E_DECODE, ex_tab[k]};
      for (int i = 0; i < seq.size(); i++) begin
        checks++;
        if (obs_a() !== seq[i]) begin
          failures++;
          $display("FAIL branch%0d cyc%0d: got %h expected %h", k, i, obs_a(), seq[i]);
        end
        tick();
      end
    end
    checks++;
    if (bus_a.instr_count !== 32'd9) begin
      failures++;
      $display("FAIL branch_retire: got %0d expected 9", bus_a.instr_count);
    end
  endtask

  task automatic test_jump_mem();
    logic [5:0]  op_tab [3] = '{6'h02, 6'h2B, 6'h23};
    logic [20:0] seq [$];
    for (int k = 0; k < 3; k++) begin
      set_a(op_tab[k], 6'h00, 6'h00);
      case (k)
        0:       seq = '{E_FETCH, E_FETCH, E_FETCH_L, E_DECODE, E_JUMP};
        1:       seq = '{E_FETCH, E_FETCH, E_FETCH_L, E_DECODE, E_MADDR, E_MEM_WR};
        default: seq = '{E_FETCH, E_FETCH, E_FETCH_L, E_DECODE, E_MADDR,
                         E_MEM_RD, E_MEM_RD, E_MEM_RD, E_WB_MEM};
      endcase
      for (int i = 0; i < seq.size(); i++) begin
        checks++;
        if (obs_a() !== seq[i]) begin
          failures++;
          $display("FAIL jump_mem%0d cyc%0d: got %h expected %h", k, i, obs_a(), seq[i]);
        end
        tick();
      end
    end
    checks++;
    if (bus_a.instr_count !== 32'd12) begin
      failures++;
      $display("FAIL jump_mem_retire: got %0d expected 12", bus_a.instr_count);
    end
  endtask

  task automatic test_halt();
    logic [20:0] seq [$];
    set_a(6'h3F, 6'h00, 6'h00);
    seq = '{E_FETCH, E_FETCH, E_FETCH_L, E_DECODE, E_RST, E_FETCH};
    for (int i = 0; i < seq.size(); i++) begin
      checks++;
      if (obs_a() !== seq[i]) begin
        failures++;
        $display("FAIL halt cyc%0d: got %h expected %h", i, obs_a(), seq[i]);
      end
      tick();
    end
    checks++;
    if (bus_a.instr_count !== 32'd12) begin
      failures++;
      $display("FAIL halt_noretire: got %0d expected 12", bus_a.instr_count);
    end
  endtask

  task automatic test_wrap_b();
    logic [3:0]  exp_cnt = 4'd0;
    logic [20:0] seq [$];
    bus_b.OPCODE = 6'h2B;
    bus_b.FUNCT  = 6'h00;
    bus_b.flags  = 6'h00;
    rst_b = 1'b1;
    tick();
    seq = '{E_FETCH_L, E_DECODE, E_MADDR, E_MEM_WR};
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < seq.size(); i++) begin
        checks++;
        if (obs_b() !== seq[i]) begin
          failures++;
          $display("FAIL wrap_sw%0d cyc%0d: got %h expected %h", k, i, obs_b(), seq[i]);
        end
        tick();
      end
      exp_cnt = exp_cnt + 4'd1;
      checks++;
      if (bus_b.instr_count !== exp_cnt) begin
        failures++;
        $display("FAIL wrap_count%0d: got %0d expected %0d", k, bus_b.instr_count, exp_cnt);
      end
    end
  endtask

  task automatic test_lw_b();
    logic [20:0] seq [$];
    bus_b.OPCODE = 6'h23;
    seq = '{E_FETCH_L, E_DECODE, E_MADDR, E_MEM_RD, E_WB_MEM, E_FETCH_L};
    for (int i = 0; i < seq.size(); i++) begin
      checks++;
      if (obs_b() !== seq[i]) begin
        failures++;
        $display("FAIL lw_w0 cyc%0d: got %h expected %h", i, obs_b(), seq[i]);
      end
      if (i < seq.size() - 1) tick();
    end
    checks++;
    if (bus_b.instr_count !== 4'd1) begin
      failures++;
      $display("FAIL lw_w0_retire: got %0d expected 1", bus_b.instr_count);
    end
  endtask

  task automatic test_abort_b();
    // Enter MEM_READ of a second LW, then drop reset between clock edges.
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (obs_b() !== E_MEM_RD) begin
      failures++;
      $display("FAIL abort_setup: got %h expected %h", obs_b(), E_MEM_RD);
    end
    rst_b = 1'b0;
    #1;
    checks++;
    if (obs_b() !== E_RST) begin
      failures++;
      $display("FAIL abort_async: got %h expected %h", obs_b(), E_RST);
    end
    checks++;
    if (bus_b.instr_count !== 4'd0) begin
      failures++;
      $display("FAIL abort_count: got %0d expected 0", bus_b.instr_count);
    end
    tick();
    rst_b = 1'b1;
    tick();
    checks++;
    if (obs_b() !== E_FETCH_L) begin
      failures++;
      $display("FAIL abort_restart: got %h expected %h", obs_b(), E_FETCH_L);
    end
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    set_a(6'h00, 6'h00, 6'h00);
    bus_b.OPCODE = 6'h00;
    bus_b.FUNCT  = 6'h00;
    bus_b.flags  = 6'h00;
    test_reset();
    test_r_add();
    test_r_funct();
    test_illegal();
    test_addi();
    test_branch();
    test_jump_mem();
    test_halt();
    test_wrap_b();
    test_lw_b();
    test_abort_b();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
